// File: rtl/pe_requant_pkg.sv
// Shared widths, lane counts and FSM encoding for the PE partial-sum requantizer.
package pe_requant_pkg;

    localparam int unsigned PSUM_W     = 64;
    localparam int unsigned ACC_W_88   = 24;
    localparam int unsigned ACC_W_18   = 16;
    localparam int unsigned BIAS_W     = 32;
    localparam int unsigned SCALE_W    = 16;
    localparam int unsigned OUT_W      = 8;
    localparam int unsigned SHIFT_W    = 5;

    localparam int unsigned LANES_88   = 2;
    localparam int unsigned LANES_18   = 4;
    localparam int unsigned LANE_IDX_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Index of the final lane of a word for the given packing mode.
    function automatic logic [LANE_IDX_W-1:0] last_lane(input logic mode);
        return mode ? LANE_IDX_W'(LANES_18 - 1) : LANE_IDX_W'(LANES_88 - 1);
    endfunction

endpackage

// File: rtl/requant_lane.sv
// Single-lane requantizer: bias add, scale multiply, round-half-up shift, saturate.
module requant_lane #(
    parameter int unsigned LANE_W  = 24,
    parameter int unsigned BIAS_W  = 32,
    parameter int unsigned SCALE_W = 16,
    parameter int unsigned SHIFT_W = 5,
    parameter int unsigned OUT_W   = 8
) (
    input  logic signed [LANE_W-1:0]  lane_in,
    input  logic signed [BIAS_W-1:0]  bias_in,
    input  logic signed [SCALE_W-1:0] scale_in,
    input  logic        [SHIFT_W-1:0] shift_in,
    output logic        [OUT_W-1:0]   data_out
);

    // Sum is one bit wider than the wider operand so the bias add never wraps.
    localparam int unsigned SUM_W  = ((LANE_W > BIAS_W) ? LANE_W : BIAS_W) + 1;
    localparam int unsigned PROD_W = SUM_W + SCALE_W;
    localparam int unsigned RND_W  = PROD_W + 1;

    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [SUM_W-1:0]  v;
    logic signed [SUM_W-1:0]  b;
    logic signed [SUM_W-1:0]  s;
    logic signed [PROD_W-1:0] s_ext;
    logic signed [PROD_W-1:0] sc_ext;
    logic signed [PROD_W-1:0] p;
    logic signed [RND_W-1:0]  p_ext;
    logic signed [RND_W-1:0]  rnd;
    logic signed [RND_W-1:0]  r;

    // Datapath: widen, add bias, multiply, add half-LSB, arithmetic shift, clamp.
    always_comb begin
        v      = {{(SUM_W - LANE_W){lane_in[LANE_W-1]}}, lane_in};
        b      = {{(SUM_W - BIAS_W){bias_in[BIAS_W-1]}}, bias_in};
        s      = v + b;
        s_ext  = {{(PROD_W - SUM_W){s[SUM_W-1]}}, s};
        sc_ext = {{(PROD_W - SCALE_W){scale_in[SCALE_W-1]}}, scale_in};
        p      = s_ext * sc_ext;
        p_ext  = {p[PROD_W-1], p};
        rnd    = '0;
        if (shift_in != '0) begin
            rnd = RND_W'(1) << (shift_in - SHIFT_W'(1));
        end
        r = (p_ext + rnd) >>> shift_in;
        if (r > SAT_MAX) begin
            data_out = SAT_MAX[OUT_W-1:0];
        end else if (r < SAT_MIN) begin
            data_out = SAT_MIN[OUT_W-1:0];
        end else begin
            data_out = r[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/pe_psum_requant.sv
// Unpacks a PE partial-sum word into 2 or 4 signed lanes and streams one
// requantized, saturated byte per lane over a ready/valid output.
module pe_psum_requant #(
    parameter int unsigned PSUM_W   = pe_requant_pkg::PSUM_W,
    parameter int unsigned ACC_W_88 = pe_requant_pkg::ACC_W_88,
    parameter int unsigned ACC_W_18 = pe_requant_pkg::ACC_W_18,
    parameter int unsigned BIAS_W   = pe_requant_pkg::BIAS_W,
    parameter int unsigned SCALE_W  = pe_requant_pkg::SCALE_W,
    parameter int unsigned OUT_W    = pe_requant_pkg::OUT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PSUM_W-1:0]     in_psum,
    input  logic [4*BIAS_W-1:0]   in_bias,
    input  logic [SCALE_W-1:0]    scale,
    input  logic [4:0]            shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [1:0]            out_lane,
    output logic                  out_last
);

    import pe_requant_pkg::*;

    state_t                 state_q, state_d;
    logic [PSUM_W-1:0]      psum_q, psum_d;
    logic [4*BIAS_W-1:0]    bias_q, bias_d;
    logic                   mode_q, mode_d;
    logic [SCALE_W-1:0]     scale_q, scale_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic [1:0]             lane_q, lane_d;
    logic [OUT_W-1:0]       data_q, data_d;
    logic                   last_q, last_d;

    logic                   accept;
    logic [PSUM_W-1:0]      sel_psum;
    logic [4*BIAS_W-1:0]    sel_bias_all;
    logic                   sel_mode;
    logic [SCALE_W-1:0]     sel_scale;
    logic [SHIFT_W-1:0]     sel_shift;
    logic [1:0]             sel_idx;
    logic [ACC_W_18-1:0]    lane16;
    logic [ACC_W_88-1:0]    sel_lane;
    logic [BIAS_W-1:0]      sel_bias;
    logic [OUT_W-1:0]       lane_result;

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_EMIT);
    assign out_data  = data_q;
    assign out_lane  = lane_q;
    assign out_last  = last_q;

    // The single lane unit serves lane 0 straight from the input port on the
    // accept cycle (so lane 0 is registered with 1-cycle latency) and the
    // following lanes from the captured word.
    always_comb begin
        if (accept) begin
            sel_psum     = in_psum;
            sel_bias_all = in_bias;
            sel_mode     = mode;
            sel_scale    = scale;
            sel_shift    = shift;
            sel_idx      = '0;
        end else begin
            sel_psum     = psum_q;
            sel_bias_all = bias_q;
            sel_mode     = mode_q;
            sel_scale    = scale_q;
            sel_shift    = shift_q;
            sel_idx      = lane_q + 2'd1;
        end
        lane16 = sel_psum[sel_idx*ACC_W_18 +: ACC_W_18];
        if (sel_mode) begin
            sel_lane = {{(ACC_W_88 - ACC_W_18){lane16[ACC_W_18-1]}}, lane16};
        end else begin
            sel_lane = sel_psum[sel_idx[0]*ACC_W_88 +: ACC_W_88];
        end
        sel_bias = sel_bias_all[sel_idx*BIAS_W +: BIAS_W];
    end

    requant_lane #(
        .LANE_W  (ACC_W_88),
        .BIAS_W  (BIAS_W),
        .SCALE_W (SCALE_W),
        .SHIFT_W (SHIFT_W),
        .OUT_W   (OUT_W)
    ) u_lane (
        .lane_in  (sel_lane),
        .bias_in  (sel_bias),
        .scale_in (sel_scale),
        .shift_in (sel_shift),
        .data_out (lane_result)
    );

    // Next-state: capture on accept, advance a lane per output handshake.
    always_comb begin
        state_d = state_q;
        psum_d  = psum_q;
        bias_d  = bias_q;
        mode_d  = mode_q;
        scale_d = scale_q;
        shift_d = shift_q;
        lane_d  = lane_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    psum_d  = in_psum;
                    bias_d  = in_bias;
                    mode_d  = mode;
                    scale_d = scale;
                    shift_d = shift;
                    lane_d  = '0;
                    data_d  = lane_result;
                    last_d  = 1'b0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        lane_d = sel_idx;
                        data_d = lane_result;
                        last_d = (sel_idx == last_lane(mode_q));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            psum_q  <= '0;
            bias_q  <= '0;
            mode_q  <= 1'b0;
            scale_q <= '0;
            shift_q <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            psum_q  <= psum_d;
            bias_q  <= bias_d;
            mode_q  <= mode_d;
            scale_q <= scale_d;
            shift_q <= shift_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_pe_psum_requant.sv
// Self-checking bench for pe_psum_requant: directed corner words, stalls,
// reset mid-word, randomized words and back-to-back streaming.
module tb_pe_psum_requant;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_psum = '0;
    logic [127:0] in_bias = '0;
    logic [15:0]  scale = '0;
    logic [4:0]   shift = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;
    logic [1:0]   out_lane;
    logic         out_last;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit           mode;
        logic [63:0]  psum;
        logic [127:0] bias;
        logic [15:0]  scale;
        logic [4:0]   shift;
    } word_t;

    pe_psum_requant #(
        .PSUM_W   (64),
        .ACC_W_88 (24),
        .ACC_W_18 (16),
        .BIAS_W   (32),
        .SCALE_W  (16),
        .OUT_W    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .in_bias   (in_bias),
        .scale     (scale),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: plain integer arithmetic on the lane value.
    function automatic int model_lane(input word_t w, input int k);
        longint lane;
        longint b;
        longint p;
        int     bi;
        shortint sc;
        if (w.mode) begin
            lane = longint'((w.psum >> (16 * k)) & 64'hFFFF);
            if (lane >= 32768) lane = lane - 65536;
        end else begin
            lane = longint'((w.psum >> (24 * k)) & 64'hFF_FFFF);
            if (lane >= 8388608) lane = lane - 16777216;
        end
        bi = w.bias[k*32 +: 32];
        b  = bi;
        sc = w.scale;
        p  = (lane + b) * sc;
        if (w.shift > 0) p = p + (longint'(1) << (w.shift - 1));
        p = p >>> w.shift;
        if (p > 127)  return 127;
        if (p < -128) return -128;
        return int'(p);
    endfunction

    function automatic word_t rand_word();
        word_t w;
        int    bb;
        w.mode = 1'($urandom_range(1));
        w.psum = {$urandom, $urandom};
        w.bias = {$urandom, $urandom, $urandom, $urandom};
        w.scale = 16'($urandom);
        w.shift = 5'($urandom);
        case ($urandom_range(2))
            0: ;
            1: begin
                for (int k = 0; k < 4; k++) begin
                    bb = int'($urandom_range(400)) - 200;
                    w.bias[k*32 +: 32] = bb;
                end
                w.scale = 16'(int'($urandom_range(10)) - 5);
                w.shift = 5'($urandom_range(4));
            end
            default: begin
                for (int k = 0; k < 4; k++) begin
                    bb = int'($urandom_range(2000)) - 1000;
                    w.bias[k*32 +: 32] = bb;
                end
                w.shift = 5'($urandom_range(16, 31));
            end
        endcase
        return w;
    endfunction

    task automatic drive_word(input word_t w);
        in_valid = 1'b1;
        mode     = w.mode;
        in_psum  = w.psum;
        in_bias  = w.bias;
        scale    = w.scale;
        shift    = w.shift;
    endtask

    task automatic scramble();
        mode    = 1'($urandom_range(1));
        in_psum = {$urandom, $urandom};
        in_bias = {$urandom, $urandom, $urandom, $urandom};
        scale   = 16'($urandom);
        shift   = 5'($urandom);
    endtask

    // Sends one word and checks every lane; inputs are scrambled (or the next
    // word is presented) while the word is in flight.
    task automatic run_word(input word_t w, input bit pre_driven, input bit have_next,
                            input word_t nxt, input int stall_pct, input int stall_lane,
                            input int stall_cycles, input string tag);
        int          n, j, cyc, held, e;
        bit          rdy;
        logic [10:0] expv, got;
        n = w.mode ? 4 : 2;
        if (!pre_driven) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s idle_ready: in_ready=%b required 1", tag, in_ready);
            end
            drive_word(w);
        end
        @(negedge clk);
        if (have_next) begin
            drive_word(nxt);
        end else begin
            scramble();
            in_valid = 1'b0;
        end
        j = 0; cyc = 0; held = 0;
        while (j < n && cyc < 200) begin
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_lane%0d: out_valid=%b in_ready=%b required 1/0",
                         tag, j, out_valid, in_ready);
            end
            e    = model_lane(w, j);
            expv = {8'(e), 2'(j), (j == n - 1)};
            got  = {out_data, out_lane, out_last};
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL %s lane%0d: data=%h lane=%0d last=%b required data=%h lane=%0d last=%b",
                         tag, j, out_data, out_lane, out_last, expv[10:3], expv[2:1], expv[0]);
            end
            if (j == stall_lane && held < stall_cycles) begin
                rdy = 1'b0;
                held++;
            end else begin
                rdy = ($urandom_range(99) >= stall_pct);
            end
            out_ready = rdy;
            @(negedge clk);
            if (rdy) j++;
            cyc++;
        end
        if (j < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: lanes done=%0d required %0d", tag, j, n);
        end
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s word_end: out_valid=%b in_ready=%b required 0/1",
                     tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({out_valid, out_data, out_lane, out_last} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%h lane=%0d last=%b required all 0",
                     out_valid, out_data, out_lane, out_last);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        word_t w;
        w.mode = 1'b0; w.psum = {16'h0, 24'hFFFF9C, 24'h000064};
        w.bias = '0; w.scale = 16'd1; w.shift = 5'd0;
        run_word(w, 1'b0, 1'b0, w, 0, -1, 0, "m0_basic");

        w.mode = 1'b1; w.psum = {16'hFFFB, 16'd7, 16'd6, 16'd5};
        w.bias = '0; w.scale = 16'd1; w.shift = 5'd1;
        run_word(w, 1'b0, 1'b0, w, 0, -1, 0, "m1_round");

        w.mode = 1'b0; w.psum = {16'hABCD, 24'h800000, 24'h7FFFFF};
        w.bias = '0; w.scale = 16'h7FFF; w.shift = 5'd0;
        run_word(w, 1'b0, 1'b0, w, 0, -1, 0, "m0_sat");

        w.mode = 1'b1; w.psum = {16'd100, 16'hFF00, 16'd300, 16'd10};
        w.bias = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFEC}; w.scale = 16'd3; w.shift = 5'd2;
        run_word(w, 1'b0, 1'b0, w, 0, -1, 0, "m1_bias");
    endtask

    task automatic test_backpressure();
        word_t w;
        w = rand_word();
        w.mode = 1'b1;
        run_word(w, 1'b0, 1'b0, w, 0, 1, 3, "stall_l1");
    endtask

    task automatic test_reset_in_emit();
        word_t w;
        w = rand_word();
        w.mode = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        drive_word(w);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_lane !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_emit_l0: out_valid=%b lane=%0d required 1/0", out_valid, out_lane);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_lane !== 2'd1) begin
            n_fail++;
            $display("FAIL rst_emit_l1: out_valid=%b lane=%0d required 1/1", out_valid, out_lane);
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({out_valid, out_data, out_lane, out_last} !== 12'h0) begin
            n_fail++;
            $display("FAIL rst_emit_clear: valid=%b data=%h lane=%0d last=%b required all 0",
                     out_valid, out_data, out_lane, out_last);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_emit_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_emit_quiet%0d: out_valid=%b required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        word_t w;
        for (int i = 0; i < 40; i++) begin
            w = rand_word();
            run_word(w, 1'b0, 1'b0, w, 30, -1, 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        word_t ws[10];
        for (int i = 0; i < 10; i++) ws[i] = rand_word();
        run_word(ws[0], 1'b0, 1'b1, ws[1], 20, -1, 0, "b2b");
        for (int i = 1; i < 10; i++) begin
            if (i < 9) run_word(ws[i], 1'b1, 1'b1, ws[i+1], 20, -1, 0, "b2b");
            else       run_word(ws[i], 1'b1, 1'b0, ws[i], 20, -1, 0, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_in_emit();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_psum_requant.md
PE_PSUM_REQUANT -- requirements
Module: pe_psum_requant

Interface
REQ-001 Parameter PSUM_W, default 64, packed accumulator width from the PE MAC.
REQ-002 Parameter ACC_W_88, default 24, lane width in mode 0 (two lanes).
REQ-003 Parameter ACC_W_18, default 16, lane width in mode 1 (four lanes).
REQ-004 Parameter BIAS_W, default 32; SCALE_W, default 16; OUT_W, default 8.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 mode  in  1  0 = two s24 lanes, 1 = four s16 lanes; sampled at input accept.
REQ-008 in_valid  in  1  in_psum holds a finished accumulation.
REQ-009 in_ready  out  1  block can accept in_psum this cycle.
REQ-010 in_psum  in  PSUM_W  packed signed accumulators.
REQ-011 in_bias  in  4*BIAS_W  per-lane signed bias, lane k at [k*BIAS_W +: BIAS_W]; sampled at accept.
REQ-012 scale  in  SCALE_W  signed multiplier, layer-static, sampled at accept.
REQ-013 shift  in  5  right-shift amount 0..31, sampled at accept.
REQ-014 out_valid  out  1  out_data valid.
REQ-015 out_ready  in  1  consumer accepts out_data.
REQ-016 out_data  out  OUT_W  signed saturated result.
REQ-017 out_lane  out  2  lane index of out_data.
REQ-018 out_last  out  1  high with final lane of current word.

Function
REQ-019 States IDLE, EMIT; in_ready SHALL equal (state == IDLE); input accepted when in_valid && in_ready.
REQ-020 On accept, in_psum, in_bias, mode, scale, shift SHALL be registered and state SHALL go to EMIT with lane index 0.
REQ-021 Lane unpack: mode 0 lane k = in_psum[24k +: 24], k=0..1, bits [63:48] ignored; mode 1 lane k = in_psum[16k +: 16], k=0..3.
REQ-022 Per lane: v = sign-extend(lane) to 33 bits; s = v + sign-extend(bias_k) (33-bit, no wrap); p = s * scale (49-bit signed).
REQ-023 Rounding: r = (p + (shift>0 ? 2^(shift-1) : 0)) >>> shift, arithmetic, round-half-up.
REQ-024 Saturation: out_data = clamp(r, -128, 127).
REQ-025 out_valid SHALL rise the cycle after accept with lane 0 result registered; latency accept-to-out_valid = 1 cycle.
REQ-026 out_data, out_lane, out_last SHALL hold stable while out_valid && !out_ready.
REQ-027 On out_valid && out_ready with non-last lane, next lane SHALL be presented next cycle (no bubble).
REQ-028 out_last SHALL be high on lane 1 in mode 0, lane 3 in mode 1.
REQ-029 On last-lane handshake, state SHALL return to IDLE and out_valid SHALL drop next cycle; in_valid in that same cycle is not accepted (in_ready low), accepted the following cycle.
REQ-030 Changes on mode, scale, shift, in_bias during EMIT SHALL have no effect on the word in flight.

Reset
REQ-031 Reset SHALL force state IDLE, out_valid 0, out_data 0, out_lane 0, out_last 0, captured registers 0; in_ready 1 the cycle after reset deasserts.
REQ-032 Reset during EMIT SHALL discard remaining lanes with no further out_valid.

Structure
REQ-033 Package pe_requant_pkg SHALL hold width constants (PSUM_W, ACC_W_88, ACC_W_18, BIAS_W, SCALE_W, OUT_W), lane counts (2, 4), and the state encoding.
REQ-034 One combinational sub-module requant_lane SHALL implement REQ-022..024 for one lane; pe_psum_requant instantiates it once, muxing the selected lane.

Verification
REQ-035 Mode 0, psum lanes 24'h000064 / 24'hFFFF9C, bias 0, scale 1, shift 0, out_ready 1 -> out_data 8'h64 (lane 0), then 8'h9C (lane 1, out_last 1), in_ready low 2 cycles.
REQ-036 Mode 1, lanes 5, 6, 7, -5, bias 0, scale 1, shift 1 -> 3, 3, 4, -2 on lanes 0..3, back-to-back cycles.
REQ-037 Mode 0, lanes 24'h7FFFFF / 24'h800000, scale 16'h7FFF, shift 0 -> 127 then -128.
REQ-038 Mode 1, lane 0 = 10, bias lane 0 = -20, scale 3, shift 2 -> lane 0 out_data -7.
REQ-039 out_ready held low 3 cycles on lane 1 -> out_data/out_lane/out_last stable, in_ready low; release -> lanes 2, 3 follow on consecutive cycles.
REQ-040 Reset asserted after lane 1 handshake in mode 1 -> out_valid 0 next cycle, no lanes 2/3 emitted, in_ready 1 after reset released.
